// File: rtl/bytes_to_word_pkg.sv
// rtl/bytes_to_word_pkg.sv - shared constants and FSM encoding for the byte-to-word assembler
package bytes_to_word_pkg;

    localparam int         DEF_NBYTES   = 4;
    localparam logic [7:0] DEF_EOT_CHAR = 8'h04;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } b2w_state_t;

endpackage

// File: rtl/bytes_to_word.sv
// rtl/bytes_to_word.sv - assembles UART receiver bytes into big-endian words with EOT framing
module bytes_to_word
    import bytes_to_word_pkg::*;
#(
    parameter int         NBYTES   = DEF_NBYTES,
    parameter logic [7:0] EOT_CHAR = DEF_EOT_CHAR,
    parameter bit         EOT_EN   = 1'b1,
    localparam int        CW       = $clog2(NBYTES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_readable,
    input  logic [7:0]          rx_data,
    output logic                rx_used_tick,
    output logic                word_valid,
    input  logic                word_ack,
    output logic [8*NBYTES-1:0] data_out,
    output logic [CW-1:0]       word_bytes,
    output logic                word_last,
    output logic                eot_tick,
    output logic                receiving_word
);

    localparam logic [CW-1:0] FULL = CW'(NBYTES);

    b2w_state_t    state;
    logic [CW-1:0] cnt;
    logic          eot_flag;
    logic          is_eot;

    // A terminator byte is only special when EOT framing is enabled
    assign is_eot = EOT_EN && (rx_data == EOT_CHAR);

    // Byte intake, word hand-off and message termination in one FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            eot_flag       <= 1'b0;
            rx_used_tick   <= 1'b0;
            word_valid     <= 1'b0;
            data_out       <= '0;
            word_bytes     <= '0;
            word_last      <= 1'b0;
            eot_tick       <= 1'b0;
            receiving_word <= 1'b0;
        end else begin
            eot_tick <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_readable) begin
                        rx_used_tick <= 1'b1;
                        state        <= ST_SETTLE;
                        if (is_eot) begin
                            eot_flag <= 1'b1;
                        end else begin
                            // Byte index 0 lands in the MSBs
                            for (int i = 0; i < NBYTES; i++) begin
                                if (cnt == CW'(i)) begin
                                    data_out[8*(NBYTES-1-i) +: 8] <= rx_data;
                                end
                            end
                            cnt            <= cnt + CW'(1);
                            receiving_word <= 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    rx_used_tick <= 1'b0;
                    // Wait for the receiver to clear so the same byte is never read twice
                    if (!rx_readable) begin
                        if (cnt == FULL) begin
                            state      <= ST_HOLD;
                            word_valid <= 1'b1;
                            word_last  <= 1'b0;
                            word_bytes <= FULL;
                        end else if (eot_flag && (cnt != '0)) begin
                            state      <= ST_HOLD;
                            word_valid <= 1'b1;
                            word_last  <= 1'b1;
                            word_bytes <= cnt;
                        end else if (eot_flag) begin
                            eot_tick <= 1'b1;
                            eot_flag <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (word_ack) begin
                        word_valid     <= 1'b0;
                        word_last      <= 1'b0;
                        word_bytes     <= '0;
                        cnt            <= '0;
                        data_out       <= '0;
                        eot_flag       <= 1'b0;
                        receiving_word <= 1'b0;
                        eot_tick       <= word_last;
                        state          <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bytes_to_word.sv
// tb/tb_bytes_to_word.sv - scoreboard bench for bytes_to_word with a message-level reference model
module tb_bytes_to_word;

    typedef struct {
        logic [31:0] data;
        int          nb;
        bit          last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_readable, rx_used_tick, word_valid, word_ack, word_last, eot_tick, receiving_word;
    logic [7:0]  rx_data;
    logic [31:0] data_out;
    logic [2:0]  word_bytes;

    logic        rx2_readable, rx2_used_tick, word2_valid, word2_ack, word2_last, eot2_tick, receiving2_word;
    logic [7:0]  rx2_data;
    logic [31:0] data2_out;
    logic [2:0]  word2_bytes;

    int   tests = 0, fails = 0;
    int   used_cnt = 0, eot_seen = 0, eot_exp = 0, eot2_seen = 0;
    int   ack_mode = 1;
    exp_t exp_q[$];
    logic [7:0] cur[$];

    always #5 clk = ~clk;

    bytes_to_word #(.NBYTES(4), .EOT_CHAR(8'h04), .EOT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .rx_readable(rx_readable), .rx_data(rx_data),
        .rx_used_tick(rx_used_tick), .word_valid(word_valid), .word_ack(word_ack),
        .data_out(data_out), .word_bytes(word_bytes), .word_last(word_last),
        .eot_tick(eot_tick), .receiving_word(receiving_word)
    );

    bytes_to_word #(.NBYTES(4), .EOT_CHAR(8'h04), .EOT_EN(1'b0)) dut_raw (
        .clk(clk), .rst(rst), .rx_readable(rx2_readable), .rx_data(rx2_data),
        .rx_used_tick(rx2_used_tick), .word_valid(word2_valid), .word_ack(word2_ack),
        .data_out(data2_out), .word_bytes(word2_bytes), .word_last(word2_last),
        .eot_tick(eot2_tick), .receiving_word(receiving2_word)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a message is a byte stream split into 4-byte big-endian words
    task automatic push_word(input bit last);
        exp_t e;
        e.data = 32'h0;
        for (int i = 0; i < cur.size(); i++) e.data[8*(3-i) +: 8] = cur[i];
        e.nb   = cur.size();
        e.last = last;
        exp_q.push_back(e);
        cur.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'h04) begin
            if (cur.size() > 0) push_word(1'b1);
            eot_exp++;
        end else begin
            cur.push_back(b);
            if (cur.size() == 4) push_word(1'b0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(posedge clk);
        model_byte(b);
        @(posedge clk); #1;
        rx_data     = b;
        rx_readable = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!rx_used_tick && t < 1000);
        if (!rx_used_tick) begin
            tests++; fails++;
            $display("FAIL byte_consume_timeout: got no rx_used_tick expected one for byte %02h", b);
        end
        @(posedge clk); #1;
        rx_readable = 1'b0;
        rx_data     = 8'($urandom);
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || word_valid) && k < 3000) begin @(negedge clk); k++; end
        chk("drain_pending_words", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Consumer side: acknowledge randomly, hold off, or force acceptance
    initial begin
        word_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ack_mode)
                0:       word_ack = ($urandom_range(0, 2) == 0);
                1:       word_ack = 1'b0;
                default: word_ack = 1'b1;
            endcase
        end
    end

    // Monitor: pop the expected word whenever the DUT hands one over
    initial begin
        bit   eot_next;
        exp_t e;
        eot_next = 1'b0;
        forever begin
            @(negedge clk);
            if (eot_next) begin
                chk("eot_on_last_ack", eot_tick, 1'b1);
                eot_next = 1'b0;
            end
            if (rst) begin
                if (rx_used_tick) used_cnt++;
                if (eot_tick)     eot_seen++;
                if (eot2_tick)    eot2_seen++;
                if (word_valid && word_ack) begin
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_word: got %08h expected no word", data_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word_data", data_out, e.data);
                        chk("word_bytes", 32'(word_bytes), 32'(e.nb));
                        chk("word_last", 32'(word_last), 32'(e.last));
                        if (e.last) eot_next = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int u0, k, t;
        rst = 1'b1;
        rx_readable = 1'b0; rx_data = 8'h00;
        rx2_readable = 1'b0; rx2_data = 8'h00; word2_ack = 1'b0;
        #3 rst = 1'b0;
        #2;
        chk("rst_word_valid", word_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_used_tick", rx_used_tick, 0);
        chk("rst_receiving", receiving_word, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // 1: plain full word, latency of word_valid after the last byte clears
        ack_mode = 1;
        u0 = used_cnt;
        send_byte(8'h55, 0);
        send_byte(8'h33, 0);
        @(negedge clk);
        chk("receiving_partial", receiving_word, 1);
        send_byte(8'h0F, 0);
        send_byte(8'h59, 0);
        @(negedge clk);
        chk("valid_not_early", word_valid, 0);
        @(negedge clk);
        chk("valid_latency", word_valid, 1);
        chk("used_ticks_word", used_cnt - u0, 4);
        ack_mode = 0;
        drain();
        chk("receiving_after_ack", receiving_word, 0);

        // 2: short message, padded word flagged last
        send_byte(8'h4D, 1);
        send_byte(8'h4D, 0);
        send_byte(8'h04, 2);
        drain();

        // 3: full word then a lone terminator
        send_byte(8'h10, 0); send_byte(8'h20, 1); send_byte(8'h30, 0); send_byte(8'h40, 0);
        send_byte(8'h04, 0);
        drain();

        // 4: backpressure while a word is pending
        ack_mode = 1;
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(8'h10, 8'hFF)), 0);
        @(posedge clk); #1;
        rx_data = 8'h11; rx_readable = 1'b1;
        model_byte(8'h11);
        u0 = used_cnt;
        repeat (100) @(negedge clk);
        chk("no_consume_while_held", used_cnt - u0, 0);
        chk("valid_while_held", word_valid, 1);
        ack_mode = 2;
        k = 0;
        while (word_valid && k < 50) begin @(negedge clk); k++; end
        ack_mode = 0;
        t = 0;
        do begin @(negedge clk); t++; end while (!rx_used_tick && t < 10);
        chk("consume_after_ack", t, 1);
        @(posedge clk); #1 rx_readable = 1'b0;
        send_byte(8'h04, 0);
        drain();

        // 5: mid-message reset discards the partial word
        send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        @(negedge clk);
        chk("receiving_before_rst", receiving_word, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_data_out", data_out, 0);
        chk("mid_rst_receiving", receiving_word, 0);
        chk("mid_rst_valid", word_valid, 0);
        chk("mid_rst_eot", eot_tick, 0);
        cur.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        send_byte(8'hA1, 0); send_byte(8'hB2, 0); send_byte(8'hC3, 0); send_byte(8'hD4, 0);
        drain();

        // Random messages
        for (int i = 0; i < 120; i++)
            send_byte(($urandom_range(0, 7) == 0) ? 8'h04 : 8'($urandom), $urandom_range(0, 3));
        send_byte(8'h04, 0);
        drain();
        chk("eot_count", eot_seen, eot_exp);

        // 6: terminator treated as data when framing is disabled
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            rx2_data = 8'h04; rx2_readable = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!rx2_used_tick && t < 20);
            chk("raw_consume", rx2_used_tick, 1);
            @(posedge clk); #1 rx2_readable = 1'b0;
        end
        t = 0;
        do begin @(negedge clk); t++; end while (!word2_valid && t < 20);
        chk("raw_data", data2_out, 32'h04040404);
        chk("raw_bytes", 32'(word2_bytes), 4);
        chk("raw_last", word2_last, 0);
        @(posedge clk); #1 word2_ack = 1'b1;
        @(posedge clk); #1 word2_ack = 1'b0;
        repeat (5) @(negedge clk);
        chk("raw_valid_cleared", word2_valid, 0);
        chk("raw_no_eot", eot2_seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
